// File: rtl/bc_score_sequencer.sv
// Bulls-and-cows scorer: captures one guess, optionally validates it, scores it one position per cycle.
// Optional build macro BC_VALIDATE_EN enables the VALIDATE state (repeated or out-of-range digit check).
//
// state    | meaning
// IDLE     | waiting for start; captures guess, player and opponent secret
// VALIDATE | one cycle; flags repeated digits or digits above MAX_DIGIT
// SCORE    | four cycles; evaluates guess position r_idx against the secret
// REPORT   | one cycle; done high, published results valid
module bc_score_sequencer #(
   parameter int MAX_DIGIT = 9
) (
   input  logic        clock,
   input  logic        reset,
   input  logic        start,
   input  logic        player,
   input  logic [15:0] guess,
   input  logic [15:0] secret_p1,
   input  logic [15:0] secret_p2,
   output logic        busy,
   output logic        done,
   output logic        invalid,
   output logic [2:0]  bulls,
   output logic [2:0]  cows,
   output logic        win
);

   typedef enum logic [1:0] {
      ST_IDLE     = 2'd0,
      ST_VALIDATE = 2'd1,
      ST_SCORE    = 2'd2,
      ST_REPORT   = 2'd3
   } state_t;

   localparam logic [3:0] LP_MAX = 4'(MAX_DIGIT);

   state_t      r_state;
   state_t      w_state_next;
   logic [1:0]  r_idx;
   logic [15:0] r_guess;
   logic [15:0] r_secret;
   logic [2:0]  r_bulls_acc;
   logic [2:0]  r_cows_acc;
   logic        r_done;
   logic [2:0]  r_bulls;
   logic [2:0]  r_cows;
   logic        r_win;

   logic [3:0]  w_g_nib;
   logic        w_bull;
   logic        w_cow;
   logic        w_bad;
   logic [2:0]  w_bulls_nxt;
   logic [2:0]  w_cows_nxt;

   function automatic logic [3:0] f_nib(input logic [15:0] v, input logic [1:0] i);
      case (i)
         2'd0:    return v[15:12];
         2'd1:    return v[11:8];
         2'd2:    return v[7:4];
         default: return v[3:0];
      endcase
   endfunction

   // Position 0 lives in the top nibble, so index 0 scores [15:12] first.
   always_comb begin
      w_g_nib = f_nib(r_guess, r_idx);
      w_bull  = (w_g_nib == f_nib(r_secret, r_idx));
      w_cow   = 1'b0;
      for (int j = 0; j < 4; j++) begin
         if ((2'(j) != r_idx) && (w_g_nib == f_nib(r_secret, 2'(j))))
            w_cow = 1'b1;
      end
      if (w_bull)
         w_cow = 1'b0;
      w_bulls_nxt = r_bulls_acc + {2'b00, w_bull};
      w_cows_nxt  = r_cows_acc + {2'b00, w_cow};
   end

   always_comb begin
      w_bad = 1'b0;
      for (int a = 0; a < 4; a++) begin
         if (f_nib(r_guess, 2'(a)) > LP_MAX)
            w_bad = 1'b1;
         for (int b = a + 1; b < 4; b++) begin
            if (f_nib(r_guess, 2'(a)) == f_nib(r_guess, 2'(b)))
               w_bad = 1'b1;
         end
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_state <= ST_IDLE;
      else
         r_state <= w_state_next;
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         ST_IDLE: begin
            if (start) begin
`ifdef BC_VALIDATE_EN
               w_state_next = ST_VALIDATE;
`else
               w_state_next = ST_SCORE;
`endif
            end
         end
         ST_VALIDATE: w_state_next = w_bad ? ST_REPORT : ST_SCORE;
         ST_SCORE:    if (r_idx == 2'd3) w_state_next = ST_REPORT;
         ST_REPORT:   w_state_next = ST_IDLE;
         default:     w_state_next = ST_IDLE;
      endcase
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_idx       <= 2'd0;
         r_guess     <= 16'd0;
         r_secret    <= 16'd0;
         r_bulls_acc <= 3'd0;
         r_cows_acc  <= 3'd0;
      end else begin
         if ((r_state == ST_IDLE) && start) begin
            r_guess     <= guess;
            r_secret    <= player ? secret_p1 : secret_p2;
            r_idx       <= 2'd0;
            r_bulls_acc <= 3'd0;
            r_cows_acc  <= 3'd0;
         end else if (r_state == ST_SCORE) begin
            r_idx       <= r_idx + 2'd1;
            r_bulls_acc <= w_bulls_nxt;
            r_cows_acc  <= w_cows_nxt;
         end
      end
   end

   // Results are loaded on the edge entering REPORT so they are valid alongside done.
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         r_done  <= 1'b0;
         r_bulls <= 3'd0;
         r_cows  <= 3'd0;
         r_win   <= 1'b0;
      end else begin
         r_done <= 1'b0;
         if (w_state_next == ST_REPORT && r_state != ST_REPORT) begin
            r_done <= 1'b1;
            if (r_state == ST_SCORE) begin
               r_bulls <= w_bulls_nxt;
               r_cows  <= w_cows_nxt;
               r_win   <= (w_bulls_nxt == 3'd4);
            end else begin
               r_bulls <= 3'd0;
               r_cows  <= 3'd0;
               r_win   <= 1'b0;
            end
         end
      end
   end

`ifdef BC_VALIDATE_EN
   logic r_invalid;

   always_ff @(posedge clock or posedge reset) begin
      if (reset)
         r_invalid <= 1'b0;
      else if (w_state_next == ST_REPORT && r_state != ST_REPORT)
         r_invalid <= (r_state == ST_VALIDATE);
   end

   assign invalid = r_invalid;
`else
   assign invalid = 1'b0;
`endif

   assign busy  = (r_state != ST_IDLE);
   assign done  = r_done;
   assign bulls = r_bulls;
   assign cows  = r_cows;
   assign win   = r_win;

endmodule

// File: tb/tb_bc_score_sequencer.sv
// Directed bench for bc_score_sequencer: scoring vectors, validation, ignored restarts and mid-run reset.
module tb_bc_score_sequencer;

   logic        clock;
   logic        reset;
   logic        start;
   logic        player;
   logic [15:0] guess;
   logic [15:0] secret_p1;
   logic [15:0] secret_p2;
   logic        busy;
   logic        done;
   logic        invalid;
   logic [2:0]  bulls;
   logic [2:0]  cows;
   logic        win;

   int n_tests;
   int n_fail;

`ifdef BC_VALIDATE_EN
   localparam int LAT_VALID = 6;
   localparam int LAT_BAD   = 2;
`else
   localparam int LAT_VALID = 5;
   localparam int LAT_BAD   = 5;
`endif

   bc_score_sequencer #(.MAX_DIGIT(9)) dut (
      .clock     (clock),
      .reset     (reset),
      .start     (start),
      .player    (player),
      .guess     (guess),
      .secret_p1 (secret_p1),
      .secret_p2 (secret_p2),
      .busy      (busy),
      .done      (done),
      .invalid   (invalid),
      .bulls     (bulls),
      .cows      (cows),
      .win       (win)
   );

   always #5 clock = ~clock;

   typedef struct packed {
      logic        p;
      logic [15:0] g;
      logic [15:0] s1;
      logic [15:0] s2;
      logic [2:0]  eb;
      logic [2:0]  ec;
      logic        ew;
   } vec_t;

   // Drives one start in cycle T; lat = cycle offset of first done after edge T (0 = none in window).
   task automatic do_op(input logic p, input logic [15:0] g, input logic [15:0] s1,
                        input logic [15:0] s2, output int lat, output int n_done);
      @(negedge clock);
      player = p; guess = g; secret_p1 = s1; secret_p2 = s2; start = 1'b1;
      @(posedge clock);
      lat = 0;
      n_done = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k == 1) start = 1'b0;
         if (done === 1'b1) begin
            n_done++;
            if (lat == 0) lat = k;
         end
      end
   endtask

   task automatic test_reset;
      reset = 1'b1;
      repeat (3) @(negedge clock);
      n_tests++;
      if ({busy, done, invalid, bulls, cows, win} !== 10'd0) begin
         n_fail++;
         $display("FAIL reset_outputs: got %b, want all 0", {busy, done, invalid, bulls, cows, win});
      end
      reset = 1'b0;
      @(negedge clock);
      n_tests++;
      if (busy !== 1'b0) begin
         n_fail++;
         $display("FAIL reset_idle_busy: got %b, want 0", busy);
      end
   endtask

   task automatic test_bulls_cows;
      vec_t tbl [6];
      int lat, nd;
      tbl[0] = '{1'b0, 16'h1234, 16'h5678, 16'h1234, 3'd4, 3'd0, 1'b1};
      tbl[1] = '{1'b0, 16'h4321, 16'h5678, 16'h1234, 3'd0, 3'd4, 1'b0};
      tbl[2] = '{1'b0, 16'h1243, 16'h5678, 16'h1234, 3'd2, 3'd2, 1'b0};
      tbl[3] = '{1'b1, 16'h5690, 16'h5678, 16'h1234, 3'd2, 3'd0, 1'b0};
      tbl[4] = '{1'b0, 16'h5690, 16'h5678, 16'h1234, 3'd0, 3'd0, 1'b0};
      tbl[5] = '{1'b0, 16'h9012, 16'h5678, 16'h1234, 3'd0, 3'd2, 1'b0};
      for (int i = 0; i < 6; i++) begin
         do_op(tbl[i].p, tbl[i].g, tbl[i].s1, tbl[i].s2, lat, nd);
         n_tests++;
         if (lat != LAT_VALID || nd != 1) begin
            n_fail++;
            $display("FAIL score_latency[%0d]: got lat=%0d dones=%0d, want lat=%0d dones=1", i, lat, nd, LAT_VALID);
         end
         n_tests++;
         if (bulls !== tbl[i].eb || cows !== tbl[i].ec || win !== tbl[i].ew || invalid !== 1'b0) begin
            n_fail++;
            $display("FAIL score_result[%0d]: got b=%0d c=%0d w=%b inv=%b, want b=%0d c=%0d w=%b inv=0",
                     i, bulls, cows, win, invalid, tbl[i].eb, tbl[i].ec, tbl[i].ew);
         end
      end
   endtask

   task automatic test_invalid;
      logic [15:0] gl [3];
      logic [2:0]  eb [3];
      logic [2:0]  ec [3];
      int lat, nd;
      gl[0] = 16'h1124; gl[1] = 16'h12A4; gl[2] = 16'h123F;
`ifdef BC_VALIDATE_EN
      eb[0] = 3'd0; ec[0] = 3'd0;
      eb[1] = 3'd0; ec[1] = 3'd0;
      eb[2] = 3'd0; ec[2] = 3'd0;
`else
      eb[0] = 3'd2; ec[0] = 3'd2;
      eb[1] = 3'd3; ec[1] = 3'd0;
      eb[2] = 3'd3; ec[2] = 3'd0;
`endif
      for (int i = 0; i < 3; i++) begin
         do_op(1'b0, gl[i], 16'h5678, 16'h1234, lat, nd);
         n_tests++;
         if (lat != LAT_BAD || nd != 1) begin
            n_fail++;
            $display("FAIL invalid_latency[%0d]: got lat=%0d dones=%0d, want lat=%0d dones=1", i, lat, nd, LAT_BAD);
         end
         n_tests++;
`ifdef BC_VALIDATE_EN
         if (invalid !== 1'b1 || bulls !== eb[i] || cows !== ec[i] || win !== 1'b0) begin
`else
         if (invalid !== 1'b0 || bulls !== eb[i] || cows !== ec[i] || win !== 1'b0) begin
`endif
            n_fail++;
            $display("FAIL invalid_result[%0d]: got inv=%b b=%0d c=%0d w=%b, want b=%0d c=%0d", i, invalid, bulls, cows, win, eb[i], ec[i]);
         end
      end
      // 9 is the largest legal digit, so this guess must be scored normally.
      do_op(1'b0, 16'h9876, 16'h5678, 16'h1234, lat, nd);
      n_tests++;
      if (lat != LAT_VALID || invalid !== 1'b0 || bulls !== 3'd0 || cows !== 3'd0) begin
         n_fail++;
         $display("FAIL max_digit_ok: got lat=%0d inv=%b b=%0d c=%0d, want lat=%0d inv=0 b=0 c=0", lat, invalid, bulls, cows, LAT_VALID);
      end
   endtask

   task automatic test_back_to_back;
      int lat, nd;
      @(negedge clock);
      player = 1'b0; guess = 16'h1234; secret_p1 = 16'h5678; secret_p2 = 16'h1234; start = 1'b1;
      @(posedge clock);
      lat = 0;
      nd = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k == 1) start = 1'b0;
         if (k == 2) start = 1'b1;
         if (k == 3) begin
            start = 1'b0;
            guess = 16'h4321;
            secret_p2 = 16'h8765;
         end
         if (done === 1'b1) begin
            nd++;
            if (lat == 0) lat = k;
         end
      end
      n_tests++;
      if (lat != LAT_VALID || nd != 1) begin
         n_fail++;
         $display("FAIL restart_ignored: got lat=%0d dones=%0d, want lat=%0d dones=1", lat, nd, LAT_VALID);
      end
      n_tests++;
      if (bulls !== 3'd4 || cows !== 3'd0 || win !== 1'b1) begin
         n_fail++;
         $display("FAIL capture_isolated: got b=%0d c=%0d w=%b, want b=4 c=0 w=1", bulls, cows, win);
      end
   endtask

   task automatic test_reset_abort;
      int nd;
      @(negedge clock);
      player = 1'b0; guess = 16'h1234; secret_p2 = 16'h1234; start = 1'b1;
      @(posedge clock);
      nd = 0;
      for (int k = 1; k <= 20; k++) begin
         @(negedge clock);
         if (k == 1) start = 1'b0;
         if (k == 2) begin
            n_tests++;
            if (busy !== 1'b1) begin
               n_fail++;
               $display("FAIL busy_mid_op: got %b, want 1", busy);
            end
         end
         if (k == 3) begin
            reset = 1'b1;
            #1;
            n_tests++;
            if ({busy, done, invalid, bulls, cows, win} !== 10'd0) begin
               n_fail++;
               $display("FAIL abort_outputs: got %b, want all 0", {busy, done, invalid, bulls, cows, win});
            end
         end
         if (k == 4) reset = 1'b0;
         if (done === 1'b1) nd++;
      end
      n_tests++;
      if (nd != 0 || busy !== 1'b0) begin
         n_fail++;
         $display("FAIL abort_no_done: got dones=%0d busy=%b, want dones=0 busy=0", nd, busy);
      end
   endtask

   initial begin
      clock = 1'b0;
      reset = 1'b1;
      start = 1'b0;
      player = 1'b0;
      guess = 16'h0000;
      secret_p1 = 16'h0000;
      secret_p2 = 16'h0000;
      n_tests = 0;
      n_fail = 0;
      test_reset;
      test_bulls_cows;
      test_invalid;
      test_back_to_back;
      test_reset_abort;
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
